// File: rtl/cfu_li2_arbiter_pkg.sv
// cfu_li2_arbiter shared definitions: counter widths and
// a modulo-increment helper for the round-robin pointer.
package cfu_li2_arbiter_pkg;

  localparam int STAT_W = 16;
  localparam int CNT_W  = 4;

  function automatic int unsigned wrap_inc(
    input int unsigned v,
    input int unsigned n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cfu_rr_pick.sv
// Combinational round-robin picker: first set bit of elig_i
// at or after ptr_i (wrapping) -> gnt_o one-hot, idx_o, any_o.
module cfu_rr_pick
  import cfu_li2_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!any_o && elig_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = W'(j);
      end
    end
  end

endmodule

// File: rtl/cfu_li2_arbiter.sv
// Round-robin LI2 CFU arbiter: N upstream ports, one CFU.
// Requests tagged {port,id}; responses routed back by tag.
// Ports: up_req_*/up_resp_* upstream, cfu_req_*/cfu_resp_*
// downstream, stray_err sticky, stat_grants per-port counts.
// Macro CFU_ARB_STATS_EN builds the grant counters.
module cfu_li2_arbiter
  import cfu_li2_arbiter_pkg::*;
#(
  parameter int N_PORTS           = 4,
  parameter int PORT_W            = $clog2(N_PORTS),
  parameter int CFU_FUNC_ID_W     = 1,
  parameter int CFU_REQ_RESP_ID_W = 8,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = 32,
  parameter int CFU_ERR_ID_W      = 32,
  parameter int MAX_OUT           = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_PORTS-1:0] up_req_valid,
  output logic [N_PORTS-1:0] up_req_ready,
  input  logic [N_PORTS*CFU_FUNC_ID_W-1:0] up_req_func_id,
  input  logic [N_PORTS*CFU_REQ_RESP_ID_W-1:0] up_req_id,
  input  logic [N_PORTS*CFU_REQ_DATA_W-1:0] up_req_data0,
  input  logic [N_PORTS*CFU_REQ_DATA_W-1:0] up_req_data1,
  output logic [N_PORTS-1:0] up_resp_valid,
  output logic [CFU_REQ_RESP_ID_W-1:0] up_resp_id,
  output logic [CFU_RESP_DATA_W-1:0] up_resp_data,
  output logic up_resp_err,
  output logic [CFU_ERR_ID_W-1:0] up_resp_err_id,
  output logic cfu_req_valid,
  input  logic cfu_req_ready,
  output logic [CFU_FUNC_ID_W-1:0] cfu_req_func_id,
  output logic [PORT_W+CFU_REQ_RESP_ID_W-1:0] cfu_req_id,
  output logic [CFU_REQ_DATA_W-1:0] cfu_req_data0,
  output logic [CFU_REQ_DATA_W-1:0] cfu_req_data1,
  input  logic cfu_resp_valid,
  input  logic [PORT_W+CFU_REQ_RESP_ID_W-1:0] cfu_resp_id,
  input  logic [CFU_RESP_DATA_W-1:0] cfu_resp_data,
  input  logic cfu_resp_err,
  input  logic [CFU_ERR_ID_W-1:0] cfu_resp_err_id,
  output logic stray_err,
  output logic [N_PORTS*STAT_W-1:0] stat_grants
);

  localparam int IW = CFU_REQ_RESP_ID_W;
  localparam int FW = CFU_FUNC_ID_W;
  localparam int DW = CFU_REQ_DATA_W;

  logic [N_PORTS-1:0] elig, gnt_oh, rsp_oh;
  logic [PORT_W-1:0]  gnt_idx, rr_q, rsp_tag;
  logic               gnt_any, slot_free, acc;
  logic               rsp_ok, stray_hit;
  logic [CNT_W-1:0]   cnt_q [N_PORTS];

  logic               full_q;
  logic [PORT_W-1:0]  port_q;
  logic [IW-1:0]      id_q;
  logic [FW-1:0]      fn_q;
  logic [DW-1:0]      d0_q, d1_q;

  logic [N_PORTS-1:0]         rv_q;
  logic [IW-1:0]              rid_q;
  logic [CFU_RESP_DATA_W-1:0] rdata_q;
  logic                       rerr_q;
  logic [CFU_ERR_ID_W-1:0]    reid_q;
  logic                       stray_q;

  always_comb begin
    elig = '0;
    for (int p = 0; p < N_PORTS; p++)
      elig[p] = up_req_valid[p] &&
                (cnt_q[p] < CNT_W'(MAX_OUT));
  end

  cfu_rr_pick #(.N(N_PORTS), .W(PORT_W)) u_pick (
    .elig_i (elig),
    .ptr_i  (rr_q),
    .gnt_o  (gnt_oh),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // Slot frees in the same cycle it is drained downstream.
  assign slot_free    = !full_q || cfu_req_ready;
  assign acc          = rst && slot_free && gnt_any;
  assign up_req_ready = acc ? gnt_oh : '0;

  assign rsp_tag = cfu_resp_id[PORT_W+IW-1:IW];

  // Only a known port with something outstanding may answer.
  always_comb begin
    rsp_oh = '0;
    for (int p = 0; p < N_PORTS; p++)
      rsp_oh[p] = cfu_resp_valid &&
                  (rsp_tag == PORT_W'(p)) &&
                  (cnt_q[p] != '0);
  end

  assign rsp_ok    = |rsp_oh;
  assign stray_hit = cfu_resp_valid && !rsp_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      port_q <= '0;
      id_q   <= '0;
      fn_q   <= '0;
      d0_q   <= '0;
      d1_q   <= '0;
      rr_q   <= '0;
    end else if (acc) begin
      full_q <= 1'b1;
      port_q <= gnt_idx;
      id_q   <= up_req_id[gnt_idx*IW +: IW];
      fn_q   <= up_req_func_id[gnt_idx*FW +: FW];
      d0_q   <= up_req_data0[gnt_idx*DW +: DW];
      d1_q   <= up_req_data1[gnt_idx*DW +: DW];
      rr_q   <= PORT_W'(wrap_inc(32'(gnt_idx), N_PORTS));
    end else if (cfu_req_ready) begin
      full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < N_PORTS; p++)
        cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if ((acc && gnt_oh[p]) && !rsp_oh[p])
          cnt_q[p] <= cnt_q[p] + CNT_W'(1);
        else if (!(acc && gnt_oh[p]) && rsp_oh[p])
          cnt_q[p] <= cnt_q[p] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rv_q    <= '0;
      rid_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      reid_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      rv_q <= rsp_oh;
      if (rsp_ok) begin
        rid_q   <= cfu_resp_id[IW-1:0];
        rdata_q <= cfu_resp_data;
        rerr_q  <= cfu_resp_err;
        reid_q  <= cfu_resp_err_id;
      end
      if (stray_hit)
        stray_q <= 1'b1;
    end
  end

  assign cfu_req_valid   = full_q;
  assign cfu_req_id      = {port_q, id_q};
  assign cfu_req_func_id = fn_q;
  assign cfu_req_data0   = d0_q;
  assign cfu_req_data1   = d1_q;

  assign up_resp_valid  = rv_q;
  assign up_resp_id     = rid_q;
  assign up_resp_data   = rdata_q;
  assign up_resp_err    = rerr_q;
  assign up_resp_err_id = reid_q;
  assign stray_err      = stray_q;

`ifdef CFU_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [N_PORTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < N_PORTS; p++)
        stat_q[p] <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++)
        if (acc && gnt_oh[p])
          stat_q[p] <= stat_q[p] + STAT_W'(1);
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int p = 0; p < N_PORTS; p++)
      stat_grants[p*STAT_W +: STAT_W] = stat_q[p];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_cfu_li2_arbiter.sv
// Bench for cfu_li2_arbiter: vector table, directed corner
// sequences and random traffic against a behavioural model.
module tb_cfu_li2_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   up_req_valid;
  logic [3:0]   up_req_ready;
  logic [3:0]   up_req_func_id;
  logic [31:0]  up_req_id;
  logic [127:0] up_req_data0, up_req_data1;
  logic [3:0]   up_resp_valid;
  logic [7:0]   up_resp_id;
  logic [31:0]  up_resp_data;
  logic         up_resp_err;
  logic [31:0]  up_resp_err_id;
  logic         cfu_req_valid;
  logic         cfu_req_ready;
  logic [0:0]   cfu_req_func_id;
  logic [9:0]   cfu_req_id;
  logic [31:0]  cfu_req_data0, cfu_req_data1;
  logic         cfu_resp_valid;
  logic [9:0]   cfu_resp_id;
  logic [31:0]  cfu_resp_data;
  logic         cfu_resp_err;
  logic [31:0]  cfu_resp_err_id;
  logic         stray_err;
  logic [63:0]  stat_grants;

  cfu_li2_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .up_req_valid    (up_req_valid),
    .up_req_ready    (up_req_ready),
    .up_req_func_id  (up_req_func_id),
    .up_req_id       (up_req_id),
    .up_req_data0    (up_req_data0),
    .up_req_data1    (up_req_data1),
    .up_resp_valid   (up_resp_valid),
    .up_resp_id      (up_resp_id),
    .up_resp_data    (up_resp_data),
    .up_resp_err     (up_resp_err),
    .up_resp_err_id  (up_resp_err_id),
    .cfu_req_valid   (cfu_req_valid),
    .cfu_req_ready   (cfu_req_ready),
    .cfu_req_func_id (cfu_req_func_id),
    .cfu_req_id      (cfu_req_id),
    .cfu_req_data0   (cfu_req_data0),
    .cfu_req_data1   (cfu_req_data1),
    .cfu_resp_valid  (cfu_resp_valid),
    .cfu_resp_id     (cfu_resp_id),
    .cfu_resp_data   (cfu_resp_data),
    .cfu_resp_err    (cfu_resp_err),
    .cfu_resp_err_id (cfu_resp_err_id),
    .stray_err       (stray_err),
    .stat_grants     (stat_grants)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural reference state
  int          m_cnt [4];
  int          m_rr;
  bit          m_full;
  logic [9:0]  m_sid;
  logic        m_sfn;
  logic [31:0] m_sd0, m_sd1;
  logic [3:0]  m_rv;
  logic [7:0]  m_rid;
  logic [31:0] m_rdata;
  logic        m_rerr;
  logic [31:0] m_reid;
  bit          m_stray;
  int          m_gr [4];

  typedef struct {
    logic [3:0] valid;
    logic       crdy;
    logic       rv;
    logic [9:0] rid;
    logic [3:0] e_rdy;
    logic       e_cv;
    logic [1:0] e_port;
    logic [3:0] e_rv;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int p = 0; p < 4; p++) begin
      m_cnt[p] = 0;
      m_gr[p]  = 0;
    end
    m_rr = 0; m_full = 0; m_sid = '0; m_sfn = '0;
    m_sd0 = '0; m_sd1 = '0; m_rv = '0; m_rid = '0;
    m_rdata = '0; m_rerr = 0; m_reid = '0; m_stray = 0;
  endfunction

  function automatic int m_pick();
    for (int i = 0; i < 4; i++) begin
      int p;
      p = (m_rr + i) % 4;
      if (up_req_valid[p] && m_cnt[p] < 2) return p;
    end
    return -1;
  endfunction

  function automatic logic [63:0] m_stat();
    logic [63:0] s;
    s = '0;
`ifdef CFU_ARB_STATS_EN
    for (int p = 0; p < 4; p++)
      s[p*16 +: 16] = 16'(m_gr[p]);
`endif
    return s;
  endfunction

  // Compare all outputs against the model, then advance it
  // by one clock using the inputs currently applied.
  task automatic step();
    int g;
    int tag;
    bit ok;
    logic [3:0] er;
    #1;
    g = m_pick();
    if (m_full && !cfu_req_ready) g = -1;
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("up_req_ready", up_req_ready, er);
    chk("cfu_req_valid", cfu_req_valid, m_full);
    if (m_full) begin
      chk("cfu_req_id", cfu_req_id, m_sid);
      chk("cfu_req_func", cfu_req_func_id, m_sfn);
      chk("cfu_req_data0", cfu_req_data0, m_sd0);
      chk("cfu_req_data1", cfu_req_data1, m_sd1);
    end
    chk("up_resp_valid", up_resp_valid, m_rv);
    if (m_rv != 0) begin
      chk("up_resp_id", up_resp_id, m_rid);
      chk("up_resp_data", up_resp_data, m_rdata);
      chk("up_resp_err", up_resp_err, m_rerr);
      chk("up_resp_err_id", up_resp_err_id, m_reid);
    end
    chk("stray_err", stray_err, m_stray);
    chk("stat_grants", stat_grants, m_stat());
    tag = int'(cfu_resp_id[9:8]);
    ok = cfu_resp_valid && m_cnt[tag] > 0;
    if (ok) begin
      m_rv = 4'(1 << tag);
      m_rid = cfu_resp_id[7:0];
      m_rdata = cfu_resp_data;
      m_rerr = cfu_resp_err;
      m_reid = cfu_resp_err_id;
      m_cnt[tag]--;
    end else begin
      m_rv = '0;
    end
    if (cfu_resp_valid && !ok) m_stray = 1;
    if (g >= 0) begin
      m_cnt[g]++;
      m_rr = (g + 1) % 4;
      m_full = 1;
      m_sid = {2'(g), up_req_id[g*8 +: 8]};
      m_sfn = up_req_func_id[g];
      m_sd0 = up_req_data0[g*32 +: 32];
      m_sd1 = up_req_data1[g*32 +: 32];
      m_gr[g] = (m_gr[g] + 1) % 65536;
    end else if (cfu_req_ready) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_up_req_ready", up_req_ready, 4'b0);
    chk("rst_cfu_req_valid", cfu_req_valid, 1'b0);
    chk("rst_cfu_req_id", cfu_req_id, 10'h0);
    chk("rst_cfu_req_data0", cfu_req_data0, 32'h0);
    chk("rst_up_resp_valid", up_resp_valid, 4'b0);
    chk("rst_up_resp_id", up_resp_id, 8'h0);
    chk("rst_up_resp_data", up_resp_data, 32'h0);
    chk("rst_stray_err", stray_err, 1'b0);
    chk("rst_stat_grants", stat_grants, 64'h0);
    up_req_valid = '0;
    cfu_req_ready = 1'b0;
    cfu_resp_valid = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic resp(input logic [9:0] id,
                      input logic [31:0] d);
    cfu_resp_valid = 1'b1;
    cfu_resp_id = id;
    cfu_resp_data = d;
    cfu_resp_err = 1'b0;
    cfu_resp_err_id = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    up_req_valid = '0;
    up_req_func_id = 4'b1010;
    up_req_id = 32'h13121110;
    up_req_data0 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    up_req_data1 = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    cfu_req_ready = 1'b0;
    cfu_resp_valid = 1'b0;
    cfu_resp_id = '0;
    cfu_resp_data = '0;
    cfu_resp_err = 1'b0;
    cfu_resp_err_id = '0;
    m_reset();

    tbl[0]  = '{4'hF, 1, 0, 10'h0,   4'b0001, 0, 2'd0, 4'b0};
    tbl[1]  = '{4'hF, 1, 0, 10'h0,   4'b0010, 1, 2'd0, 4'b0};
    tbl[2]  = '{4'hF, 1, 0, 10'h0,   4'b0100, 1, 2'd1, 4'b0};
    tbl[3]  = '{4'hF, 1, 0, 10'h0,   4'b1000, 1, 2'd2, 4'b0};
    tbl[4]  = '{4'hF, 1, 0, 10'h0,   4'b0001, 1, 2'd3, 4'b0};
    tbl[5]  = '{4'hF, 1, 0, 10'h0,   4'b0010, 1, 2'd0, 4'b0};
    tbl[6]  = '{4'hF, 1, 0, 10'h0,   4'b0100, 1, 2'd1, 4'b0};
    tbl[7]  = '{4'hF, 1, 0, 10'h0,   4'b1000, 1, 2'd2, 4'b0};
    tbl[8]  = '{4'hF, 1, 0, 10'h0,   4'b0000, 1, 2'd3, 4'b0};
    tbl[9]  = '{4'hF, 1, 1, 10'h121, 4'b0000, 0, 2'd0, 4'b0};
    tbl[10] = '{4'hF, 1, 0, 10'h0,   4'b0010, 0, 2'd0, 4'b0010};

    @(negedge clk);
    do_reset();

    // Round-robin order, per-port limit, response reopen
    for (int i = 0; i < 11; i++) begin
      up_req_valid = tbl[i].valid;
      cfu_req_ready = tbl[i].crdy;
      if (tbl[i].rv) resp(tbl[i].rid, 32'h99);
      else cfu_resp_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_rdy", i), up_req_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_cv", i), cfu_req_valid, tbl[i].e_cv);
      if (tbl[i].e_cv)
        chk($sformatf("tbl%0d_port", i),
            cfu_req_id[9:8], tbl[i].e_port);
      chk($sformatf("tbl%0d_rv", i), up_resp_valid, tbl[i].e_rv);
      step();
    end
    cfu_resp_valid = 1'b0;
    do_reset();

    // Single request id=5 from port 0, response data 7
    up_req_id = 32'h13121105;
    cfu_req_ready = 1'b1;
    up_req_valid = 4'b0001;
    step();
    up_req_valid = '0;
    #1;
    chk("p0_cfu_valid", cfu_req_valid, 1'b1);
    chk("p0_cfu_id", cfu_req_id, 10'h005);
    step();
    resp(10'h005, 32'd7);
    step();
    cfu_resp_valid = 1'b0;
    #1;
    chk("p0_resp_valid", up_resp_valid, 4'b0001);
    chk("p0_resp_id", up_resp_id, 8'd5);
    chk("p0_resp_data", up_resp_data, 32'd7);
    step();
    #1;
    chk("p0_resp_pulse", up_resp_valid, 4'b0000);
    step();

    // Stray response to idle port 2, sticky
    resp(10'h233, 32'h55);
    step();
    cfu_resp_valid = 1'b0;
    #1;
    chk("stray_drop", up_resp_valid, 4'b0000);
    chk("stray_set", stray_err, 1'b1);
    step();
    step();
    #1;
    chk("stray_sticky", stray_err, 1'b1);

    // Reset while a request sits in the slot
    cfu_req_ready = 1'b0;
    up_req_valid = 4'b0001;
    step();
    step();
    do_reset();
    resp(10'h005, 32'h77);
    step();
    cfu_resp_valid = 1'b0;
    #1;
    chk("late_stray", stray_err, 1'b1);
    chk("late_drop", up_resp_valid, 4'b0000);
    step();
    do_reset();

    // Downstream stall then drain-and-accept
    up_req_id = 32'h13121110;
    cfu_req_ready = 1'b1;
    up_req_valid = 4'b0100;
    step();
    cfu_req_ready = 1'b0;
    up_req_valid = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rdy", up_req_ready, 4'b0);
      chk("stall_id", cfu_req_id, 10'h212);
      step();
    end
    cfu_req_ready = 1'b1;
    #1;
    chk("drain_acc", up_req_ready, 4'b1000);
    step();
    up_req_valid = '0;
    step();

    // Port 1 hits its outstanding limit
    up_req_valid = 4'b0010;
    step();
    step();
    #1;
    chk("max_block", up_req_ready, 4'b0000);
    step();
    up_req_valid = 4'b0011;
    #1;
    chk("max_other", up_req_ready, 4'b0001);
    step();
    up_req_valid = '0;
    resp(10'h111, 32'h1);
    step();
    cfu_resp_valid = 1'b0;
    up_req_valid = 4'b0010;
    #1;
    chk("max_reopen", up_req_ready, 4'b0010);
    step();
    up_req_valid = '0;
    step();
    do_reset();

    // Three accepts on port 3
    cfu_req_ready = 1'b1;
    up_req_valid = 4'b1000;
    step();
    step();
    up_req_valid = '0;
    resp(10'h313, 32'h3);
    step();
    cfu_resp_valid = 1'b0;
    step();
    up_req_valid = 4'b1000;
    step();
    up_req_valid = '0;
    step();
    #1;
`ifdef CFU_ARB_STATS_EN
    chk("stat_p3", stat_grants[63:48], 16'd3);
`else
    chk("stat_p3", stat_grants[63:48], 16'd0);
`endif
    chk("stat_p0", stat_grants[15:0], 16'd0);
    step();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      int s;
      int tag;
      up_req_valid = 4'($urandom);
      up_req_func_id = 4'($urandom);
      up_req_id = $urandom;
      up_req_data0 = {$urandom, $urandom, $urandom, $urandom};
      up_req_data1 = {$urandom, $urandom, $urandom, $urandom};
      cfu_req_ready = ($urandom % 4) != 0;
      if ($urandom % 3 == 0) begin
        s = int'($urandom % 4);
        tag = s;
        for (int i = 0; i < 4; i++)
          if (m_cnt[(s + i) % 4] > 0) begin
            tag = (s + i) % 4;
            break;
          end
        if ($urandom % 16 == 0) tag = int'($urandom % 4);
        cfu_resp_valid = 1'b1;
        cfu_resp_id = {2'(tag), 8'($urandom)};
        cfu_resp_data = $urandom;
        cfu_resp_err = 1'($urandom);
        cfu_resp_err_id = $urandom;
      end else begin
        cfu_resp_valid = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
